// File: rtl/wave_sequencer.sv
// Step sequencer that plays a programmable list of notes into one WaveGen voice.
// Each step word is {WaveType[17:16], Frequency[15:8], Duration[7:0]}.
module wave_sequencer #(
    parameter int STEPS    = 16,
    parameter int ADDR_W   = 4,
    parameter int TICK_DIV = 256
) (
    input  logic              Clock,
    input  logic              ResetN,
    input  logic              WriteEn,
    input  logic [ADDR_W-1:0] WriteAddr,
    input  logic [17:0]       WriteData,
    input  logic [ADDR_W-1:0] LastStep,
    input  logic              Loop,
    input  logic              Start,
    input  logic              Stop,
    output logic [7:0]        Frequency,
    output logic [1:0]        WaveType,
    output logic              Gate,
    output logic [ADDR_W-1:0] Step,
    output logic              Busy
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] step_next;
    logic [7:0]        freq_next;
    logic [1:0]        wave_next;
    logic [PW-1:0]     presc, presc_next;
    logic [8:0]        dur, dur_next;
    logic [17:0]       mem [STEPS];
    logic [17:0]       word;
    logic              tick_wrap;
    logic              final_tick;

    // Unreset pattern memory; the LOAD read below sees the pre-edge contents.
    always_ff @(posedge Clock) begin
        if (WriteEn) begin
            mem[WriteAddr] <= WriteData;
        end
    end

    assign word = mem[Step];

    always_comb begin
        state_next = state;
        step_next  = Step;
        freq_next  = Frequency;
        wave_next  = WaveType;
        presc_next = presc;
        dur_next   = dur;
        tick_wrap  = (presc == TICK_LAST);
        final_tick = tick_wrap && (dur == 9'd1);

        case (state)
            IDLE: begin
                step_next  = '0;
                freq_next  = '0;
                wave_next  = '0;
                presc_next = '0;
                dur_next   = '0;
                if (Start && !Stop) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                freq_next  = word[15:8];
                wave_next  = word[17:16];
                // A zero duration means the longest note, 256 ticks.
                dur_next   = (word[7:0] == 8'd0) ? 9'd256 : {1'b0, word[7:0]};
                presc_next = '0;
                state_next = PLAY;
            end
            PLAY: begin
                if (tick_wrap) begin
                    presc_next = '0;
                    dur_next   = dur - 9'd1;
                end else begin
                    presc_next = presc + PW'(1);
                end
                if (final_tick) begin
                    if (Step != LastStep) begin
                        step_next  = Step + ADDR_W'(1);
                        state_next = LOAD;
                    end else if (Loop) begin
                        step_next  = '0;
                        state_next = LOAD;
                    end else begin
                        step_next  = '0;
                        freq_next  = '0;
                        wave_next  = '0;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Stop overrides both the end-of-step decision and a pending Start.
        if (state != IDLE && Stop) begin
            state_next = IDLE;
            step_next  = '0;
            freq_next  = '0;
            wave_next  = '0;
            presc_next = '0;
            dur_next   = '0;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state     <= IDLE;
            Step      <= '0;
            Frequency <= '0;
            WaveType  <= '0;
            presc     <= '0;
            dur       <= '0;
            Gate      <= 1'b0;
            Busy      <= 1'b0;
        end else begin
            state     <= state_next;
            Step      <= step_next;
            Frequency <= freq_next;
            WaveType  <= wave_next;
            presc     <= presc_next;
            dur       <= dur_next;
            Gate      <= (state_next == PLAY);
            Busy      <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_wave_sequencer.sv
// Directed bench for wave_sequencer: three instances with TICK_DIV 4, 2 and 1
// share the same stimulus; each test checks the instance it was written for.
module tb_wave_sequencer;

    logic        clk;
    logic        rst_n;
    logic        write_en;
    logic [3:0]  write_addr;
    logic [17:0] write_data;
    logic [3:0]  last_step;
    logic        loop_en;
    logic        start;
    logic        stop;

    logic [7:0] freq_a, freq_b, freq_c;
    logic [1:0] wave_a, wave_b, wave_c;
    logic       gate_a, gate_b, gate_c;
    logic [3:0] step_a, step_b, step_c;
    logic       busy_a, busy_b, busy_c;

    int checks   = 0;
    int failures = 0;

    wave_sequencer #(.STEPS(16), .ADDR_W(4), .TICK_DIV(4)) dut_a (
        .Clock(clk), .ResetN(rst_n), .WriteEn(write_en), .WriteAddr(write_addr),
        .WriteData(write_data), .LastStep(last_step), .Loop(loop_en),
        .Start(start), .Stop(stop), .Frequency(freq_a), .WaveType(wave_a),
        .Gate(gate_a), .Step(step_a), .Busy(busy_a)
    );

    wave_sequencer #(.STEPS(16), .ADDR_W(4), .TICK_DIV(2)) dut_b (
        .Clock(clk), .ResetN(rst_n), .WriteEn(write_en), .WriteAddr(write_addr),
        .WriteData(write_data), .LastStep(last_step), .Loop(loop_en),
        .Start(start), .Stop(stop), .Frequency(freq_b), .WaveType(wave_b),
        .Gate(gate_b), .Step(step_b), .Busy(busy_b)
    );

    wave_sequencer #(.STEPS(16), .ADDR_W(4), .TICK_DIV(1)) dut_c (
        .Clock(clk), .ResetN(rst_n), .WriteEn(write_en), .WriteAddr(write_addr),
        .WriteData(write_data), .LastStep(last_step), .Loop(loop_en),
        .Start(start), .Stop(stop), .Frequency(freq_c), .WaveType(wave_c),
        .Gate(gate_c), .Step(step_c), .Busy(busy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic start_v, input logic stop_v);
        start = start_v;
        stop  = stop_v;
        tick();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic write_step(input logic [3:0] addr, input logic [17:0] data);
        write_en   = 1'b1;
        write_addr = addr;
        write_data = data;
        tick();
        write_en   = 1'b0;
    endtask

    // One period of the three-step loop (D=1,2,1 at TICK_DIV=2), indexed by cycle mod 11.
    logic gate_tab [11] = '{0, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};
    int   step_tab [11] = '{0, 0, 0, 1, 1, 1, 1, 1, 2, 2, 2};
    int   freq_tab [11] = '{30, 10, 10, 10, 20, 20, 20, 20, 20, 30, 30};

    initial begin
        int first;
        int width;
        int cap_freq;
        int cap_wave;
        int fall_seen;
        int fall_busy;
        int fall_freq;

        rst_n      = 1'b0;
        write_en   = 1'b0;
        write_addr = '0;
        write_data = '0;
        last_step  = '0;
        loop_en    = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;

        #12;
        checkOutput("reset_freq", 32'(freq_a), 32'd0);
        checkOutput("reset_wave", 32'(wave_a), 32'd0);
        checkOutput("reset_gate", 32'(gate_a), 32'd0);
        checkOutput("reset_step", 32'(step_a), 32'd0);
        checkOutput("reset_busy", 32'(busy_a), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] single step, TICK_DIV=4");
        write_step(4'd0, {2'b01, 8'd40, 8'd3});
        last_step = 4'd0;
        loop_en   = 1'b0;
        applyStimulus(1'b1, 1'b0);
        checkOutput("single_load_busy", 32'(busy_a), 32'd1);
        checkOutput("single_load_gate", 32'(gate_a), 32'd0);
        first = -1; width = 0; cap_freq = -1; cap_wave = -1;
        fall_seen = 0; fall_busy = -1; fall_freq = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (gate_a) begin
                width++;
                if (first < 0) begin
                    first    = k;
                    cap_freq = int'(freq_a);
                    cap_wave = int'(wave_a);
                end
            end else if (first >= 0 && fall_seen == 0) begin
                fall_seen = 1;
                fall_busy = int'(busy_a);
                fall_freq = int'(freq_a);
            end
        end
        checkOutput("single_gate_start", 32'(first), 32'd1);
        checkOutput("single_gate_width", 32'(width), 32'd12);
        checkOutput("single_freq", 32'(cap_freq), 32'd40);
        checkOutput("single_wave", 32'(cap_wave), 32'd1);
        checkOutput("single_end_seen", 32'(fall_seen), 32'd1);
        checkOutput("single_end_busy", 32'(fall_busy), 32'd0);
        checkOutput("single_end_freq", 32'(fall_freq), 32'd0);

        $display("[TB] asynchronous reset mid-play");
        applyStimulus(1'b1, 1'b0);
        tick();
        tick();
        checkOutput("midplay_gate_before", 32'(gate_a), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_gate", 32'(gate_a), 32'd0);
        checkOutput("async_reset_busy", 32'(busy_a), 32'd0);
        checkOutput("async_reset_freq", 32'(freq_a), 32'd0);
        checkOutput("async_reset_wave", 32'(wave_a), 32'd0);
        checkOutput("async_reset_step", 32'(step_a), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        applyStimulus(1'b1, 1'b0);
        tick();
        checkOutput("mem_retained_freq", 32'(freq_a), 32'd40);
        for (int k = 0; k < 14; k++) tick();
        checkOutput("retained_play_done", 32'(busy_a), 32'd0);

        $display("[TB] three-step loop, TICK_DIV=2, with write collision");
        write_step(4'd0, {2'b00, 8'd10, 8'd1});
        write_step(4'd1, {2'b10, 8'd20, 8'd2});
        write_step(4'd2, {2'b11, 8'd30, 8'd1});
        last_step = 4'd2;
        loop_en   = 1'b1;
        applyStimulus(1'b1, 1'b0);
        checkOutput("loop_k0_step", 32'(step_b), 32'd0);
        checkOutput("loop_k0_gate", 32'(gate_b), 32'd0);
        checkOutput("loop_k0_busy", 32'(busy_b), 32'd1);
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k <= 21) begin
                checkOutput($sformatf("loop_k%0d_gate", k), 32'(gate_b), 32'(gate_tab[k % 11]));
                checkOutput($sformatf("loop_k%0d_step", k), 32'(step_b), 32'(step_tab[k % 11]));
                checkOutput($sformatf("loop_k%0d_freq", k), 32'(freq_b), 32'(freq_tab[k % 11]));
            end
            if (k == 25) begin
                write_en   = 1'b1;
                write_addr = 4'd1;
                write_data = {2'b01, 8'd99, 8'd2};
            end
            if (k == 26) begin
                write_en = 1'b0;
                checkOutput("collision_old_freq", 32'(freq_b), 32'd20);
                checkOutput("collision_old_wave", 32'(wave_b), 32'd2);
            end
            if (k == 37) begin
                checkOutput("collision_new_freq", 32'(freq_b), 32'd99);
                checkOutput("collision_new_wave", 32'(wave_b), 32'd1);
            end
        end
        checkOutput("loop_k40_gate", 32'(gate_b), 32'd1);

        $display("[TB] stop with start, restart, start while busy");
        applyStimulus(1'b1, 1'b1);
        checkOutput("stopstart_busy", 32'(busy_b), 32'd0);
        checkOutput("stopstart_gate", 32'(gate_b), 32'd0);
        checkOutput("stopstart_freq", 32'(freq_b), 32'd0);
        checkOutput("stopstart_step", 32'(step_b), 32'd0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("restart_busy", 32'(busy_b), 32'd1);
        checkOutput("restart_step", 32'(step_b), 32'd0);
        tick();
        checkOutput("restart_play_freq", 32'(freq_b), 32'd10);
        applyStimulus(1'b1, 1'b0);
        checkOutput("busy_start_gate", 32'(gate_b), 32'd1);
        checkOutput("busy_start_step", 32'(step_b), 32'd0);
        tick();
        checkOutput("busy_start_next_gate", 32'(gate_b), 32'd0);
        checkOutput("busy_start_next_step", 32'(step_b), 32'd1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("stop_busy", 32'(busy_b), 32'd0);

        $display("[TB] zero duration, TICK_DIV=1");
        write_step(4'd0, {2'b10, 8'd77, 8'd0});
        last_step = 4'd0;
        loop_en   = 1'b0;
        applyStimulus(1'b1, 1'b0);
        first = -1; width = 0; fall_seen = 0; fall_busy = -1;
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (gate_c) begin
                width++;
                if (first < 0) first = k;
            end else if (first >= 0 && fall_seen == 0) begin
                fall_seen = 1;
                fall_busy = int'(busy_c);
            end
        end
        checkOutput("d0_gate_start", 32'(first), 32'd1);
        checkOutput("d0_gate_width", 32'(width), 32'd256);
        checkOutput("d0_end_seen", 32'(fall_seen), 32'd1);
        checkOutput("d0_end_busy", 32'(fall_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
